sipo_deserializer: RTL and testbench

//  Serial-in/parallel-out deserializer downstream of the D flip-flop sampling stage.

---
 rtl/deser_pkg.sv | 21 ++
 rtl/sipo_deserializer_bit_counter.sv | 32 +++
 rtl/sipo_deserializer.sv | 124 ++++++++++++
 tb/tb_sipo_deserializer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// Shared definitions for the serial-in/parallel-out deserializer.
//   state_t        FSM encoding (S_DATA collects data bits, S_PAR waits for the parity bit)
//   clog2          ceiling log2 with a floor of 1, used to size the bit counter
//   DEFAULT_WIDTH  default word width
package deser_pkg;

    typedef enum logic [0:0] {
        S_DATA = 1'b0,
        S_PAR  = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sipo_deserializer_bit_counter.sv
// Mod-WIDTH up-counter with enable and wrap flag.
//   clk   clock
//   rst   asynchronous, active-high reset (count returns to 0)
//   en    count enable
//   wrap  high when enabled on the last count (WIDTH-1); counter returns to 0 on that edge
module bit_counter
    import deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic wrap
);

    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt;

    assign wrap = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer with a one-word output holding register.
// Optional even-parity bit after each word, enabled by defining PARITY_CHECK_EN.
//   clk         clock
//   rst         asynchronous, active-high reset
//   d           serial data bit
//   d_valid     d is sampled on this posedge when 1
//   m_data      assembled word, stable while m_valid=1
//   m_valid     word available
//   m_ready     consumer accepts word when m_valid & m_ready
//   overrun     sticky, a completed word was dropped because the holding register was full
//   ovr_clr     synchronous clear of overrun (a same-cycle set wins)
//   parity_err  one-cycle pulse on parity mismatch (always 0 without PARITY_CHECK_EN)
//
// state  | meaning
// S_DATA | collecting WIDTH data bits
// S_PAR  | next valid bit is the even-parity bit for the word in the shift register
module sipo_deserializer
    import deser_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             overrun,
    input  logic             ovr_clr,
    output logic             parity_err
);

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nxt;
    logic [WIDTH-1:0] cword;
    logic             cnt_en;
    logic             wrap;
    logic             complete;

    bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
        .clk  (clk),
        .rst  (rst),
        .en   (cnt_en),
        .wrap (wrap)
    );

    // After WIDTH shifts the first bit received sits at the end selected by MSB_FIRST.
    always_comb begin
        sreg_nxt = sreg;
        if (MSB_FIRST) begin
            sreg_nxt = {sreg[WIDTH-2:0], d};
        end else begin
            sreg_nxt = {d, sreg[WIDTH-1:1]};
        end
    end

`ifdef PARITY_CHECK_EN
    state_t state;
    logic   par_bit;
    logic   par_fail;

    // The parity bit is not shifted in, so the shift register holds the word during S_PAR.
    assign cnt_en   = d_valid && (state == S_DATA);
    assign par_bit  = d_valid && (state == S_PAR);
    assign complete = par_bit && ((^sreg) == d);
    assign par_fail = par_bit && ((^sreg) != d);
    assign cword    = sreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_DATA;
            parity_err <= 1'b0;
        end else begin
            parity_err <= par_fail;
            case (state)
                S_DATA:  if (wrap)    state <= S_PAR;
                S_PAR:   if (d_valid) state <= S_DATA;
                default:              state <= S_DATA;
            endcase
        end
    end
`else
    // Word is complete on the edge that samples its last bit, so load the shifted value directly.
    assign cnt_en     = d_valid;
    assign complete   = wrap;
    assign cword      = sreg_nxt;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= '0;
        end else if (cnt_en) begin
            sreg <= sreg_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (complete) begin
                // A same-cycle handshake frees the holding register, so no bubble and no loss.
                if (!m_valid || m_ready) begin
                    m_data  <= cword;
                    m_valid <= 1'b1;
                end
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end

            if (complete && m_valid && !m_ready) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_deserializer.sv
module tb_sipo_deserializer;

    logic       clk;
    logic       rst;
    logic       d;
    logic       d_valid;
    logic       m_ready;
    logic       ovr_clr;

    logic [7:0] m_data_l, m_data_m;
    logic       m_valid_l, m_valid_m;
    logic       overrun_l, overrun_m;
    logic       perr_l, perr_m;

    int n_tests;
    int n_fail;

    logic [7:0] q_l[$];
    logic [7:0] q_m[$];

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .d(d), .d_valid(d_valid),
        .m_data(m_data_l), .m_valid(m_valid_l), .m_ready(m_ready),
        .overrun(overrun_l), .ovr_clr(ovr_clr), .parity_err(perr_l)
    );

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .d(d), .d_valid(d_valid),
        .m_data(m_data_m), .m_valid(m_valid_m), .m_ready(m_ready),
        .overrun(overrun_m), .ovr_clr(ovr_clr), .parity_err(perr_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Consumer side of the scoreboard: every handshake pops and compares.
    task automatic tick();
        if (m_valid_l && m_ready) begin
            if (q_l.size() == 0) chk("sb_lsb_unexpected_word", 32'(m_data_l), 32'hDEAD);
            else chk("sb_lsb_word", 32'(m_data_l), 32'(q_l.pop_front()));
        end
        if (m_valid_m && m_ready) begin
            if (q_m.size() == 0) chk("sb_msb_unexpected_word", 32'(m_data_m), 32'hDEAD);
            else chk("sb_msb_word", 32'(m_data_m), 32'(q_m.pop_front()));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap);
        d       = b;
        d_valid = 1'b1;
        tick();
        d_valid = 1'b0;
        d       = 1'b0;
        repeat (gap) tick();
    endtask

    // Bits go out w[0] first: the LSB-first DUT rebuilds w, the MSB-first DUT rev8(w).
    task automatic send_word(input logic [7:0] w, input int gap, input bit push);
        if (push) begin
            q_l.push_back(w);
            q_m.push_back(rev8(w));
        end
        for (int i = 0; i < 8; i++) begin
`ifdef PARITY_CHECK_EN
            send_bit(w[i], gap);
`else
            send_bit(w[i], (i == 7) ? 0 : gap);
`endif
        end
`ifdef PARITY_CHECK_EN
        send_bit(^w, 0);
`endif
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        d       = 1'b0;
        d_valid = 1'b0;
        m_ready = 1'b0;
        ovr_clr = 1'b0;
        rst     = 1'b1;
        #12;
        chk("rst_m_valid", 32'(m_valid_l), 0);
        chk("rst_m_data", 32'(m_data_l), 0);
        chk("rst_overrun", 32'(overrun_l), 0);
        chk("rst_parity_err", 32'(perr_l), 0);
        rst = 1'b0;
        tick();

        // 1: continuous bits, consumer ready
        m_ready = 1'b1;
        send_word(8'h4D, 0, 1'b1);
        chk("t1_valid", 32'(m_valid_l), 1);
        chk("t1_data_lsb", 32'(m_data_l), 32'h4D);
        chk("t1_data_msb", 32'(m_data_m), 32'hB2);
        tick();
        chk("t1_valid_one_cycle", 32'(m_valid_l), 0);

        // 2: same bits with 3-cycle gaps
        send_word(8'h4D, 3, 1'b1);
        chk("t2_valid", 32'(m_valid_m), 1);
        chk("t2_data_msb", 32'(m_data_m), 32'hB2);
        chk("t2_data_lsb", 32'(m_data_l), 32'h4D);
        tick();
        chk("t2_valid_drop", 32'(m_valid_m), 0);

        // 3: back-pressure and overrun
        m_ready = 1'b0;
        send_word(8'hA5, 0, 1'b1);
        chk("t3_first_valid", 32'(m_valid_l), 1);
        chk("t3_no_overrun_yet", 32'(overrun_l), 0);
        send_word(8'h3C, 1, 1'b0);
        chk("t3_data_held_lsb", 32'(m_data_l), 32'hA5);
        chk("t3_data_held_msb", 32'(m_data_m), 32'hA5);
        chk("t3_overrun_lsb", 32'(overrun_l), 1);
        chk("t3_overrun_msb", 32'(overrun_m), 1);
        tick();
        chk("t3_overrun_sticky", 32'(overrun_l), 1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("t3_overrun_clr", 32'(overrun_l), 0);
        chk("t3_still_valid", 32'(m_valid_l), 1);
        m_ready = 1'b1;
        tick();
        chk("t3_valid_drop", 32'(m_valid_l), 0);

        // 4: handshake on the completion cycle of word 2
        m_ready = 1'b0;
        send_word(8'h11, 0, 1'b1);
        q_l.push_back(8'h96);
        q_m.push_back(rev8(8'h96));
        for (int i = 0; i < 7; i++) send_bit(1'(8'h96 >> i), 0);
`ifdef PARITY_CHECK_EN
        send_bit(1'b1, 0);
        m_ready = 1'b1;
        send_bit(^8'h96, 0);
`else
        m_ready = 1'b1;
        send_bit(1'b1, 0);
`endif
        chk("t4_valid_kept", 32'(m_valid_l), 1);
        chk("t4_data_word2", 32'(m_data_l), 32'h96);
        chk("t4_data_word2_msb", 32'(m_data_m), 32'h69);
        chk("t4_no_overrun", 32'(overrun_l), 0);
        tick();
        chk("t4_valid_drop", 32'(m_valid_l), 0);
        chk("t4_queue_drained", 32'(q_l.size() + q_m.size()), 0);

        // 5: reset mid-word discards the partial word
        for (int i = 0; i < 5; i++) send_bit(1'b0, 0);
        rst = 1'b1;
        #2;
        chk("t5_async_rst_data", 32'(m_data_l), 0);
        chk("t5_async_rst_valid", 32'(m_valid_l), 0);
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
        chk("t5_no_early_word", 32'(m_valid_l), 0);
        q_l.push_back(8'hFF);
        q_m.push_back(8'hFF);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
`ifdef PARITY_CHECK_EN
        send_bit(1'b0, 0);
`endif
        chk("t5_valid", 32'(m_valid_l), 1);
        chk("t5_data", 32'(m_data_l), 32'hFF);
        tick();
        chk("t5_parity_err_low", 32'(perr_l | perr_m), 0);

`ifdef PARITY_CHECK_EN
        // 6: parity accept and reject
        send_word(8'h03, 0, 1'b1);
        chk("t6_accept_valid", 32'(m_valid_l), 1);
        chk("t6_accept_data", 32'(m_data_l), 32'h03);
        chk("t6_accept_no_perr", 32'(perr_l), 0);
        tick();
        for (int i = 0; i < 8; i++) send_bit(1'(8'h03 >> i), 0);
        chk("t6_no_word_before_parity", 32'(m_valid_l), 0);
        send_bit(1'b1, 0);
        chk("t6_perr_pulse", 32'(perr_l), 1);
        chk("t6_perr_pulse_msb", 32'(perr_m), 1);
        chk("t6_reject_no_valid", 32'(m_valid_l), 0);
        tick();
        chk("t6_perr_one_cycle", 32'(perr_l), 0);
        chk("t6_overrun_untouched", 32'(overrun_l), 0);
`endif

        chk("end_queue_empty", 32'(q_l.size() + q_m.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
